vga_rect_compositor: RTL and testbench

- Pixel source directly upstream of the VGA timing driver.
- Holds a table of filled, prioritised rectangles plus a background colour, and turns the driver's next_x/next_y into the 8-bit RRRGGGBB color_in for that pixel.
- A host (HPS bridge / command decoder) writes a shadow copy of the table through a valid/ready port.
- The shadow copy is copied into the active table only at a vsync falling edge, after a commit request, so a frame never shows a partially written scene.

---
 rtl/vga_rect_compositor.sv | 137 +++++++++++++
 tb/tb_vga_rect_compositor.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_compositor.sv
// vga_rect_compositor: rectangle-table pixel source feeding the VGA timing driver.
// The host edits a shadow table; the shadow is published to the active table
// only on a vsync falling edge after a commit request, so frames never tear.
module vga_rect_compositor #(
    parameter int unsigned NUM_RECTS = 8,
    parameter logic [7:0]  BG_RESET  = 8'h00,
    localparam int unsigned COORD_W  = 10,
    localparam int unsigned COLOR_W  = 8,
    localparam int unsigned ADDR_W   = 4,
    localparam int unsigned ENTRY_W  = 1 + COLOR_W + 4 * COORD_W,
    localparam int unsigned FRAME_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [COORD_W-1:0] next_x,
    input  logic [COORD_W-1:0] next_y,
    input  logic               vsync,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic               wr_err,
    input  logic               commit_req,
    output logic               commit_pending,
    output logic [FRAME_W-1:0] frame_count,
    output logic [COLOR_W-1:0] color_out
);

    // One rectangle entry, laid out exactly as the host write word.
    typedef struct packed {
        logic               en;
        logic [COLOR_W-1:0] colour;
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
    } rect_t;

    rect_t              shadow_q [NUM_RECTS];
    rect_t              active_q [NUM_RECTS];
    logic [COLOR_W-1:0] shadow_bg_q;
    logic [COLOR_W-1:0] active_bg_q;
    logic               vsync_d;

    logic               wr_accept_c;
    logic               addr_bg_c;
    logic               addr_bad_c;
    logic               vsync_fall_c;
    rect_t              wr_entry_c;
    logic [NUM_RECTS-1:0] hit_c;

    // Host handshake and address decode; writes are blocked while a commit is queued.
    always_comb begin
        wr_ready     = ~commit_pending;
        wr_accept_c  = wr_valid & ~commit_pending;
        addr_bg_c    = (wr_addr == ADDR_W'(NUM_RECTS));
        addr_bad_c   = (wr_addr >  ADDR_W'(NUM_RECTS));
        vsync_fall_c = vsync_d & ~vsync;
        wr_entry_c   = rect_t'(wr_data);
    end

    // Shadow table: updated by accepted host writes to rectangle or background addresses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_RECTS); i++) begin
                shadow_q[i] <= '0;
            end
            shadow_bg_q <= BG_RESET;
        end else if (wr_accept_c) begin
            for (int i = 0; i < int'(NUM_RECTS); i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    shadow_q[i] <= wr_entry_c;
                end
            end
            if (addr_bg_c) begin
                shadow_bg_q <= wr_data[47:40];
            end
        end
    end

    // Active table: whole shadow (including background) copied at a committed frame boundary.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_RECTS); i++) begin
                active_q[i] <= '0;
            end
            active_bg_q <= BG_RESET;
        end else if (vsync_fall_c && commit_pending) begin
            active_q    <= shadow_q;
            active_bg_q <= shadow_bg_q;
        end
    end

    // Frame boundary detection, frame counter, commit flag and invalid-address pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            vsync_d        <= 1'b1;
            frame_count    <= '0;
            commit_pending <= 1'b0;
            wr_err         <= 1'b0;
        end else begin
            vsync_d <= vsync;
            wr_err  <= wr_accept_c & addr_bad_c;
            if (vsync_fall_c) begin
                frame_count <= frame_count + FRAME_W'(1);
            end
            // A request landing on the publishing edge is ignored because pending is set;
            // a request on a non-pending edge only queues for the next boundary.
            if (vsync_fall_c && commit_pending) begin
                commit_pending <= 1'b0;
            end else if (commit_req && !commit_pending) begin
                commit_pending <= 1'b1;
            end
        end
    end

    // Per-entry inclusive hit test; inverted rectangles (x0>x1 or y0>y1) never hit.
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < int'(NUM_RECTS); i++) begin
            hit_c[i] = active_q[i].en
                     & (next_x >= active_q[i].x0) & (next_x <= active_q[i].x1)
                     & (next_y >= active_q[i].y0) & (next_y <= active_q[i].y1);
        end
    end

    // Priority select: lowest-index hit wins, otherwise the active background.
    always_comb begin
        color_out = active_bg_q;
        for (int i = int'(NUM_RECTS) - 1; i >= 0; i--) begin
            if (hit_c[i]) begin
                color_out = active_q[i].colour;
            end
        end
    end

endmodule

// File: tb/tb_vga_rect_compositor.sv
// tb_vga_rect_compositor: directed stimulus with a queue-based scoreboard.
// Stimulus pushes expected values and raises a probe; a monitor pops and
// compares against the DUT outputs on the falling clock edge.
module tb_vga_rect_compositor;

    localparam int unsigned NUM_RECTS = 8;

    localparam int K_COLOR = 0;
    localparam int K_READY = 1;
    localparam int K_PEND  = 2;
    localparam int K_FC    = 3;
    localparam int K_ERR   = 4;

    logic        clock;
    logic        reset;
    logic [9:0]  next_x;
    logic [9:0]  next_y;
    logic        vsync;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [48:0] wr_data;
    logic        wr_err;
    logic        commit_req;
    logic        commit_pending;
    logic [15:0] frame_count;
    logic [7:0]  color_out;

    vga_rect_compositor #(
        .NUM_RECTS (NUM_RECTS),
        .BG_RESET  (8'h00)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .next_x         (next_x),
        .next_y         (next_y),
        .vsync          (vsync),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_err         (wr_err),
        .commit_req     (commit_req),
        .commit_pending (commit_pending),
        .frame_count    (frame_count),
        .color_out      (color_out)
    );

    // 25 MHz pixel clock
    initial clock = 1'b0;
    always #20 clock = ~clock;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    logic probe;
    int   n_checks;
    int   n_fail;

    exp_t        mon_e;
    logic [15:0] mon_act;

    // Monitor: compares one queued expectation per probed cycle
    always @(negedge clock) begin
        if (probe) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: no expected value queued");
            end else begin
                mon_e = sb.pop_front();
                case (mon_e.kind)
                    K_COLOR: mon_act = {8'h00, color_out};
                    K_READY: mon_act = {15'h0, wr_ready};
                    K_PEND:  mon_act = {15'h0, commit_pending};
                    K_FC:    mon_act = frame_count;
                    default: mon_act = {15'h0, wr_err};
                endcase
                if (mon_act !== mon_e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    function automatic logic [48:0] ent(input logic en, input logic [7:0] col,
                                        input int x0, input int y0, input int x1, input int y1);
        return {en, col, 10'(x0), 10'(y0), 10'(x1), 10'(y1)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Queue one expectation and let the monitor check it during this cycle
    task automatic chk(input int kind, input logic [15:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic pix(input int x, input int y, input logic [7:0] exp, input string name);
        next_x = 10'(x);
        next_y = 10'(y);
        chk(K_COLOR, {8'h00, exp}, name);
    endtask

    // Bounded write: hold valid until a cycle with ready is seen
    task automatic do_write(input logic [3:0] a, input logic [48:0] d);
        bit   done;
        logic rdy;
        done     = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clock);
            rdy = wr_ready;
            @(posedge clock);
            #1;
            if (rdy) done = 1'b1;
        end
        wr_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic vsync_fall();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
    endtask

    task automatic commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        probe      = 1'b0;
        reset      = 1'b0;
        next_x     = '0;
        next_y     = '0;
        vsync      = 1'b1;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        commit_req = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Reset state
        pix(0, 0, 8'h00, "rst_color_0_0");
        pix(15, 25, 8'h00, "rst_color_15_25");
        pix(639, 479, 8'h00, "rst_color_639_479");
        chk(K_READY, 16'd1, "rst_ready");
        chk(K_PEND, 16'd0, "rst_pending");
        chk(K_FC, 16'd0, "rst_frame_count");
        chk(K_ERR, 16'd0, "rst_wr_err");

        // Uncommitted write stays invisible across frames
        do_write(4'd0, ent(1'b1, 8'hE0, 10, 20, 19, 29));
        repeat (3) vsync_fall();
        pix(15, 25, 8'h00, "nocommit_color");
        chk(K_FC, 16'd3, "nocommit_frame_count");

        // Commit publishes at the next vsync fall; inclusive edges
        commit();
        chk(K_PEND, 16'd1, "commit_pending_set");
        chk(K_READY, 16'd0, "commit_ready_low");
        vsync_fall();
        chk(K_PEND, 16'd0, "commit_pending_clear");
        chk(K_FC, 16'd4, "commit_frame_count");
        pix(10, 20, 8'hE0, "edge_10_20");
        pix(19, 29, 8'hE0, "edge_19_29");
        pix(20, 29, 8'h00, "edge_20_29");
        pix(9, 20, 8'h00, "edge_9_20");
        pix(19, 30, 8'h00, "edge_19_30");

        // Overlap priority
        do_write(4'd0, ent(1'b1, 8'hE0, 0, 0, 99, 99));
        do_write(4'd3, ent(1'b1, 8'h1C, 50, 50, 149, 149));
        commit();
        vsync_fall();
        pix(60, 60, 8'hE0, "prio_60_60");
        pix(99, 99, 8'hE0, "prio_99_99");
        pix(100, 100, 8'h1C, "prio_100_100");
        pix(120, 120, 8'h1C, "prio_120_120");
        pix(200, 200, 8'h00, "prio_bg_200_200");

        // Background write plus an inverted rectangle
        do_write(4'd8, ent(1'b0, 8'h03, 0, 0, 0, 0));
        do_write(4'd0, ent(1'b1, 8'hFF, 30, 10, 20, 40));
        do_write(4'd3, ent(1'b0, 8'h1C, 50, 50, 149, 149));
        commit();
        vsync_fall();
        pix(25, 25, 8'h03, "inv_25_25");
        pix(30, 20, 8'h03, "inv_30_20");
        pix(60, 60, 8'h03, "inv_60_60");
        chk(K_FC, 16'd6, "inv_frame_count");

        // Invalid addresses: one-cycle error pulse, table untouched
        do_write(4'd15, ent(1'b1, 8'hFF, 0, 0, 639, 479));
        chk(K_ERR, 16'd1, "err15_pulse");
        chk(K_ERR, 16'd0, "err15_clear");
        do_write(4'd9, ent(1'b1, 8'hFF, 0, 0, 639, 479));
        chk(K_ERR, 16'd1, "err9_pulse");
        chk(K_ERR, 16'd0, "err9_clear");
        commit();
        vsync_fall();
        pix(60, 60, 8'h03, "err_table_unchanged");
        pix(300, 300, 8'h03, "err_table_unchanged_2");

        // Write held while pending: accepted only after the publishing edge
        commit();
        next_x   = 10'd5;
        next_y   = 10'd5;
        wr_valid = 1'b1;
        wr_addr  = 4'd1;
        wr_data  = ent(1'b1, 8'h55, 0, 0, 9, 9);
        chk(K_READY, 16'd0, "hold_ready_low_a");
        chk(K_READY, 16'd0, "hold_ready_low_b");
        vsync = 1'b0;
        chk(K_PEND, 16'd1, "hold_pend_before_edge");
        vsync = 1'b1;
        chk(K_READY, 16'd1, "hold_ready_after_edge");
        wr_valid = 1'b0;
        pix(5, 5, 8'h03, "hold_not_in_commit");
        chk(K_FC, 16'd8, "hold_frame_count");
        commit();
        vsync_fall();
        pix(5, 5, 8'h55, "hold_write_landed");

        // Commit request coincident with a vsync fall lands one frame later
        do_write(4'd2, ent(1'b1, 8'hAA, 200, 200, 210, 210));
        commit_req = 1'b1;
        vsync      = 1'b0;
        tick();
        commit_req = 1'b0;
        vsync      = 1'b1;
        chk(K_PEND, 16'd1, "coinc_pending");
        pix(205, 205, 8'h03, "coinc_not_yet");
        chk(K_FC, 16'd10, "coinc_frame_count");
        vsync_fall();
        pix(205, 205, 8'hAA, "coinc_landed");
        chk(K_PEND, 16'd0, "coinc_pending_clear");
        chk(K_FC, 16'd11, "coinc_frame_count_2");

        // Write and commit request in the same cycle: write is included
        wr_valid   = 1'b1;
        wr_addr    = 4'd4;
        wr_data    = ent(1'b1, 8'h77, 300, 300, 310, 310);
        commit_req = 1'b1;
        tick();
        wr_valid   = 1'b0;
        commit_req = 1'b0;
        chk(K_PEND, 16'd1, "same_cycle_pending");
        pix(305, 305, 8'h03, "same_cycle_before");
        vsync_fall();
        pix(305, 305, 8'h77, "same_cycle_after");
        chk(K_FC, 16'd12, "same_cycle_frame_count");

        // Reset while pending discards commit and clears both tables
        do_write(4'd5, ent(1'b1, 8'h99, 400, 400, 410, 410));
        commit();
        chk(K_PEND, 16'd1, "rst2_pending_before");
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk(K_PEND, 16'd0, "rst2_pending_clear");
        chk(K_FC, 16'd0, "rst2_frame_count");
        pix(205, 205, 8'h00, "rst2_active_cleared");
        pix(5, 5, 8'h00, "rst2_active_cleared_2");
        chk(K_READY, 16'd1, "rst2_ready");
        commit();
        vsync_fall();
        pix(305, 305, 8'h00, "rst2_shadow_cleared");
        pix(405, 405, 8'h00, "rst2_shadow_cleared_2");
        chk(K_FC, 16'd1, "rst2_frame_count_2");

        tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
